arb_request_queues_2: RTL and testbench
=======================================

# arb_request_queues_2

Two-channel request queueing stage that sits directly upstream of the two-request round-robin arbiter. It buffers incoming words from two independent valid/ready sources in per-channel FIFOs and drives the arbiter's `requests` vector from FIFO occupancy. It consumes the arbiter's one-hot `grants` and pops the granted FIFO. The popped word and its source index are presented on a registered output.

## Interface
Parameters:
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4: entries per channel FIFO; power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in0_valid` input 1: channel 0 word offered.
- `in0_data` input WIDTH: channel 0 word.
- `in0_ready` output 1: channel 0 FIFO can accept.
- `in1_valid` input 1: channel 1 word offered.
- `in1_data` input WIDTH: channel 1 word.
- `in1_ready` output 1: channel 1 FIFO can accept.
- `requests` output 2: bit i set means channel i has a word pending; goes to the arbiter.
- `grants` input 2: one-hot grant from the arbiter, combinational in the same cycle.
- `out_valid` output 1: registered; a granted word is present this cycle.
- `out_data` output WIDTH: registered granted word.
- `out_src` output 1: registered index of the channel that supplied `out_data`.
- `grant_err` output 1: sticky flag for an illegal grant.

## Operation
- **Per-channel FIFO:**
  - Circular buffer with read and write pointers of width log2(DEPTH).
  - Count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- **Input handshake:**
  - `inX_ready` = count_X != DEPTH. It depends only on state, with no pop look-through.
  - A push occurs when `inX_valid` and `inX_ready` are both high at the clock edge.
- **Request generation:** `requests[i]` = count_i != 0. Without the bypass feature, `requests` depends only on registered state.
- **Pop qualification:**
  - Channel i pops when `grants[i]` and `requests[i]` are both set and `grants` is not 2'b11.
  - A grant bit on a channel with no request is ignored and sets `grant_err`.
  - `grants` = 2'b11 causes no pop at all and sets `grant_err`.
  - `grants` = 2'b00 is legal and means no pop.
- **Output register:**
  - On a pop edge: `out_valid` <= 1, `out_data` <= the popped head word, `out_src` <= the popped channel index.
  - On any other edge: `out_valid` <= 0; `out_data` and `out_src` hold their values.
  - There is no backpressure on the output; the downstream must accept every word.
- **Simultaneous push and pop on one channel:** count is unchanged and both pointers advance. This is legal in any non-full state. A full FIFO never pushes because `inX_ready` is low.
- **Both channels pushing in one cycle:** independent and legal.
- **`grant_err`:** once set it stays set until `rst`.

## Timing
- **Reset values (asynchronous, immediate):**
  - All counts and pointers 0.
  - `requests` = 2'b00.
  - `in0_ready` = `in1_ready` = 1.
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `grant_err` = 0.
  - FIFO storage is not reset.
- **Push to empty, bypass disabled:**
  - The push happens at edge N.
  - `requests[i]` rises after edge N.
  - If granted in that cycle, the pop happens at edge N+1 and `out_valid` is high after edge N+1.
  - Input-to-output latency is 2 cycles.
- **Back-to-back pops:** a channel with count ≥ 2 that is continuously granted pops every cycle, so `out_valid` stays high each cycle.
- **Reset mid-operation:**
  - All queued words are discarded.
  - `out_valid` drops immediately.
  - Nothing is popped in the cycle `rst` deasserts.

## Configuration
- **`ARB_REQ_QUEUES_BYPASS_EN` defined:**
  - `requests[i]` = (count_i != 0) OR (`inX_valid` AND count_i == 0).
  - When channel i is empty and the word is offered and granted in the same cycle, the word goes straight to the output register and is not written to the FIFO. Count stays 0.
  - Input-to-output latency becomes 1 cycle.
- **`ARB_REQ_QUEUES_BYPASS_EN` undefined:** behaviour is exactly as described in Operation and Timing.
- **In both configurations:** `in_ready`, FIFO ordering, and the `grant_err` rules are unchanged.

## Test plan
- **Reset:** assert `rst` asynchronously mid-clock with both FIFOs holding 2 words.
  - Required: `requests` = 00, `in_ready` = 11, `out_valid` = 0 immediately.
  - Required: no `out_valid` in the first cycle after release.
- **Fill channel 0:** push 4 words 0xA0..0xA3 on channel 0 with `grants` = 00.
  - Required: `in0_ready` = 0 after the 4th push; a 5th offer is not taken; `requests` = 01.
- **Drain with the real arbiter:**
  - Connect the two-request round-robin arbiter and preload ch0 = {0x10, 0x11} and ch1 = {0x20, 0x21}.
  - Required: outputs are 0x10(src0), 0x20(src1), 0x11(src0), 0x21(src1) on consecutive cycles.
- **Simultaneous push and pop:** ch1 holds count 1 and is pushed 0x33 while granted.
  - Required: count stays 1 and `out_data` = the old head.
- **Illegal grants:**
  - Drive `grants` = 11 with both channels requesting. Required: no pop and `grant_err` = 1.
  - Drive `grants` = 10 while `requests` = 01. Required: no pop and `grant_err` stays 1.
- **Bypass (macro defined):** from empty, offer 0x5A on ch0 with `grants` = 01 in the same cycle.
  - Required: `out_valid` = 1, `out_data` = 0x5A and `out_src` = 0 after one edge; ch0 count = 0.
  - Required with the macro undefined: the same stimulus gives output after two edges.

Source files
------------

// File: rtl/arb_request_queues_2.sv
// arb_request_queues_2
//   Two-channel request queueing stage in front of a two-request round-robin
//   arbiter. Each channel buffers words from a valid/ready source in a
//   DEPTH-entry circular FIFO. FIFO occupancy drives `requests`. The one-hot
//   `grants` from the arbiter pops the granted FIFO into a registered output.
//
//   Optional feature: define ARB_REQ_QUEUES_BYPASS_EN to let a word offered to
//   an empty channel raise its request in the same cycle. If that request is
//   granted, the word goes straight to the output register.
//
//   Ports:
//     clk, rst                   clock, asynchronous active-high reset
//     in0_valid/in0_data/in0_ready  channel 0 input handshake
//     in1_valid/in1_data/in1_ready  channel 1 input handshake
//     requests[1:0]              per-channel pending-word flags to the arbiter
//     grants[1:0]                one-hot grant from the arbiter (same cycle)
//     out_valid/out_data/out_src registered popped word and its channel index
//     grant_err                  sticky illegal-grant flag
module arb_request_queues_2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             grant_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem     [2][DEPTH];
  logic [AW-1:0]    rd_ptr  [2];
  logic [AW-1:0]    wr_ptr  [2];
  logic [CW-1:0]    count   [2];
  logic [WIDTH-1:0] in_data [2];

  logic [1:0]       in_valid;
  logic [1:0]       ready;
  logic [1:0]       pop;
  logic [1:0]       fifo_pop;
  logic [1:0]       bypass;
  logic [1:0]       push;
  logic             grants_legal;
  logic             err_set;
  logic             sel;
  logic [WIDTH-1:0] pop_data;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in0_ready  = ready[0];
  assign in1_ready  = ready[1];

  always_comb begin
    ready        = '0;
    requests     = '0;
    fifo_pop     = '0;
    bypass       = '0;
    push         = '0;
    grants_legal = (grants != 2'b11);
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i] = (count[i] != CW'(DEPTH));
`ifdef ARB_REQ_QUEUES_BYPASS_EN
      requests[i] = (count[i] != '0) | (in_valid[i] & (count[i] == '0));
`else
      requests[i] = (count[i] != '0);
`endif
    end
    pop = grants & requests & {2{grants_legal}};
    for (int unsigned i = 0; i < 2; i++) begin
      // A pop of an empty channel can only be a bypass pop: the offered word
      // is consumed directly, so it must not also be written into the FIFO.
      fifo_pop[i] = pop[i] & (count[i] != '0);
      bypass[i]   = pop[i] & (count[i] == '0);
      push[i]     = in_valid[i] & ready[i] & ~bypass[i];
    end
    err_set  = ~grants_legal | (|(grants & ~requests));
    sel      = pop[1];
    pop_data = bypass[sel] ? in_data[sel] : mem[sel][rd_ptr[sel]];
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i])     wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (fifo_pop[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], fifo_pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (|pop) begin
        out_valid <= 1'b1;
        out_data  <= pop_data;
        out_src   <= sel;
      end else begin
        out_valid <= 1'b0;
      end
      if (err_set) grant_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_request_queues_2.sv
module tb_arb_request_queues_2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in0_valid = 1'b0;
  logic [7:0] in0_data = '0;
  logic       in0_ready;
  logic       in1_valid = 1'b0;
  logic [7:0] in1_data = '0;
  logic       in1_ready;
  logic [1:0] requests;
  logic [1:0] grants;
  logic [1:0] tb_grants = 2'b00;
  logic       use_arb = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       grant_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference two-request round-robin arbiter (last-granted gets lowest priority).
  logic       last_gnt;
  logic [1:0] arb_g;
  always_comb begin
    if (requests == 2'b11) arb_g = last_gnt ? 2'b01 : 2'b10;
    else                   arb_g = requests;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) last_gnt <= 1'b1;
    else if (use_arb && arb_g != 2'b00) last_gnt <= arb_g[1];
  end
  assign grants = use_arb ? arb_g : tb_grants;

  always #5 clk = ~clk;

  arb_request_queues_2 #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .requests(requests), .grants(grants),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .grant_err(grant_err)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (requests !== 2'b00) begin n_err++; $display("FAIL rst_requests got %b want 00", requests); end
    n_cmp++; if ({in1_ready, in0_ready} !== 2'b11) begin n_err++; $display("FAIL rst_ready got %b want 11", {in1_ready, in0_ready}); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00 || out_src !== 1'b0) begin n_err++; $display("FAIL rst_out got %h/%b want 00/0", out_data, out_src); end
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL rst_grant_err got %b want 0", grant_err); end
    rst = 1'b0;
    // load ch0 = 01,02,03 and ch1 = 04,05
    in0_valid = 1'b1; in0_data = 8'h01; in1_valid = 1'b1; in1_data = 8'h04; cycle();
    in0_data = 8'h02; in1_data = 8'h05; cycle();
    in0_data = 8'h03; in1_valid = 1'b0; cycle();
    in0_valid = 1'b0;
    tb_grants = 2'b01; cycle();
    tb_grants = 2'b00;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin n_err++; $display("FAIL pre_rst_pop got %b/%h want 1/01", out_valid, out_data); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (requests !== 2'b00) begin n_err++; $display("FAIL midrst_requests got %b want 00", requests); end
    n_cmp++; if ({in1_ready, in0_ready} !== 2'b11) begin n_err++; $display("FAIL midrst_ready got %b want 11", {in1_ready, in0_ready}); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    #2 rst = 1'b0;
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (requests !== 2'b00) begin n_err++; $display("FAIL post_rst_requests got %b want 00", requests); end
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    in0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = 8'hA0 + 8'(k);
      cycle();
    end
    n_cmp++; if (in0_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b want 0", in0_ready); end
    n_cmp++; if (requests !== 2'b01) begin n_err++; $display("FAIL fill_requests got %b want 01", requests); end
    in0_data = 8'hA4; cycle();
    in0_valid = 1'b0;
    n_cmp++; if (in0_ready !== 1'b0) begin n_err++; $display("FAIL fill_5th_ready got %b want 0", in0_ready); end
    tb_grants = 2'b01;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 3) tb_grants = 2'b00;
      exp = 8'hA0 + 8'(k);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp || out_src !== 1'b0) begin
        n_err++; $display("FAIL fill_drain%0d got %b/%h/%b want 1/%h/0", k, out_valid, out_data, out_src, exp);
      end
    end
    n_cmp++; if (requests !== 2'b00 || in0_ready !== 1'b1) begin n_err++; $display("FAIL fill_empty got req %b rdy %b want 00 1", requests, in0_ready); end
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL fill_grant_err got %b want 0", grant_err); end
  endtask

  task automatic test_rr_drain();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11; exp_d[3] = 8'h21;
    exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h10; in1_valid = 1'b1; in1_data = 8'h20; cycle();
    in0_data = 8'h11; in1_data = 8'h21; cycle();
    in0_valid = 1'b0; in1_valid = 1'b0;
    use_arb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_src !== exp_s[k]) begin
        n_err++; $display("FAIL rr_drain%0d got %b/%h/%b want 1/%h/%b", k, out_valid, out_data, out_src, exp_d[k], exp_s[k]);
      end
    end
    cycle();
    use_arb = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || requests !== 2'b00) begin n_err++; $display("FAIL rr_done got %b/%b want 0/00", out_valid, requests); end
  endtask

  task automatic test_push_pop();
    in1_valid = 1'b1; in1_data = 8'h30; cycle();
    in1_data = 8'h33; tb_grants = 2'b10; cycle();
    in1_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h30 || out_src !== 1'b1) begin
      n_err++; $display("FAIL pp_pop got %b/%h/%b want 1/30/1", out_valid, out_data, out_src);
    end
    n_cmp++; if (requests !== 2'b10) begin n_err++; $display("FAIL pp_count got req %b want 10", requests); end
    cycle();
    tb_grants = 2'b00;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin n_err++; $display("FAIL pp_second got %b/%h want 1/33", out_valid, out_data); end
    n_cmp++; if (requests !== 2'b00) begin n_err++; $display("FAIL pp_empty got %b want 00", requests); end
  endtask

  task automatic test_bypass();
    in0_valid = 1'b1; in0_data = 8'h5A; tb_grants = 2'b01; cycle();
    in0_valid = 1'b0;
`ifdef ARB_REQ_QUEUES_BYPASS_EN
    tb_grants = 2'b00;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0) begin
      n_err++; $display("FAIL byp_out got %b/%h/%b want 1/5a/0", out_valid, out_data, out_src);
    end
    n_cmp++; if (requests !== 2'b00 || in0_ready !== 1'b1) begin n_err++; $display("FAIL byp_count got req %b rdy %b want 00 1", requests, in0_ready); end
`else
    n_cmp++; if (out_valid !== 1'b0 || requests !== 2'b01) begin n_err++; $display("FAIL nobyp_edge1 got %b/%b want 0/01", out_valid, requests); end
    cycle();
    tb_grants = 2'b00;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0) begin
      n_err++; $display("FAIL nobyp_out got %b/%h/%b want 1/5a/0", out_valid, out_data, out_src);
    end
    n_cmp++; if (requests !== 2'b00) begin n_err++; $display("FAIL nobyp_empty got %b want 00", requests); end
`endif
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL byp_idle got %b want 0", out_valid); end
  endtask

  task automatic test_illegal_grants();
    // clear any error left from earlier stimulus
    rst = 1'b1; #2 rst = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h40; in1_valid = 1'b1; in1_data = 8'h41; cycle();
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL ill_pre got %b want 0", grant_err); end
    tb_grants = 2'b11; cycle();
    n_cmp++; if (out_valid !== 1'b0 || requests !== 2'b11) begin n_err++; $display("FAIL ill_11_nopop got %b/%b want 0/11", out_valid, requests); end
    n_cmp++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL ill_11_err got %b want 1", grant_err); end
    tb_grants = 2'b10; cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h41 || out_src !== 1'b1) begin
      n_err++; $display("FAIL ill_legal_pop got %b/%h/%b want 1/41/1", out_valid, out_data, out_src);
    end
    cycle();
    n_cmp++; if (out_valid !== 1'b0 || requests !== 2'b01) begin n_err++; $display("FAIL ill_10_nopop got %b/%b want 0/01", out_valid, requests); end
    n_cmp++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL ill_10_err got %b want 1", grant_err); end
    tb_grants = 2'b01; cycle();
    tb_grants = 2'b00;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h40 || out_src !== 1'b0) begin
      n_err++; $display("FAIL ill_ch0_kept got %b/%h/%b want 1/40/0", out_valid, out_data, out_src);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_fill();
    test_rr_drain();
    test_push_pop();
    test_bypass();
    test_illegal_grants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached 20000 want finish");
    $fatal(1);
  end

endmodule
